zap_sync_fifo_flex: RTL and testbench

- Parametrised successor to the team's synchronous FIFO.
- Adds the following over the current block:
  - Selectable output mode: first-word-fall-through or registered read.
  - Registered occupancy count.
  - Almost-full and almost-empty thresholds.
  - Synchronous flush.
  - Optional sticky overflow/underflow error flags.
- Used between CPU pipeline/cache/bus-interface stages wherever depth, thresholds or read mode must differ per instance.

---
 rtl/zap_sync_fifo_flex.sv | 171 +++++++++++++++++
 tb/tb_zap_sync_fifo_flex.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/zap_sync_fifo_flex.sv
// zap_sync_fifo_flex: parameterised synchronous FIFO.
// Selectable first-word-fall-through or registered-read output, registered
// occupancy count, almost-full/almost-empty thresholds and synchronous flush.
// Optional sticky overflow/underflow flags are built when the macro
// ZAP_SYNC_FIFO_ERR_CHECK_EN is defined; otherwise o_ovf/o_udf read as 0.
module zap_sync_fifo_flex #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 1,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_flush,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_ack,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic                     o_empty,
    output logic                     o_full,
    output logic                     o_afull,
    output logic                     o_aempty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_ovf,
    output logic                     o_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] ONE      = PW'(1);
    localparam logic [PW-1:0] AF_THRESH = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [PW-1:0]    count_q, count_d;
    logic             empty_q, empty_d;
    logic             full_q, full_d;
    logic             afull_q, afull_d;
    logic             aempty_q, aempty_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic             wrAccept;
    logic             rdAccept;
    logic             bypassHead;

    // Flush overrides both requests; a full FIFO drops writes, an empty one ignores reads
    always_comb begin
        wrAccept = i_wr_en && !full_q && !i_flush;
        rdAccept = i_ack && !empty_q && !i_flush;
    end

    // Next pointers, occupancy and flags; all flags derive from the next state
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (i_flush) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end else begin
            if (wrAccept) begin
                wrPtr_d = wrPtr_q + ONE;
            end
            if (rdAccept) begin
                rdPtr_d = rdPtr_q + ONE;
            end
            case ({wrAccept, rdAccept})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
        empty_d  = (wrPtr_d == rdPtr_d);
        full_d   = (wrPtr_d[AW-1:0] == rdPtr_d[AW-1:0]) && (wrPtr_d[AW] != rdPtr_d[AW]);
        afull_d  = (count_d >= AF_THRESH);
        aempty_d = (count_d <= AE_THRESH);
    end

    // Output data/valid: FWFT tracks the next head (with same-cycle write bypass),
    // registered mode captures the head only on an accepted read
    always_comb begin
        data_d     = data_q;
        valid_d    = 1'b0;
        bypassHead = wrAccept && (wrPtr_q[AW-1:0] == rdPtr_d[AW-1:0]);
        if (FWFT != 0) begin
            valid_d = !empty_d;
            if (!i_flush && !empty_d) begin
                data_d = bypassHead ? i_data : mem_q[rdPtr_d[AW-1:0]];
            end
        end else begin
            valid_d = rdAccept;
            if (rdAccept) begin
                data_d = mem_q[rdPtr_q[AW-1:0]];
            end
        end
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge i_clk) begin
        if (wrAccept) begin
            mem_q[wrPtr_q[AW-1:0]] <= i_data;
        end
    end

    // Control and output state registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wrPtr_q  <= '0;
            rdPtr_q  <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

`ifdef ZAP_SYNC_FIFO_ERR_CHECK_EN
    logic ovf_q;
    logic udf_q;

    // Sticky error flags: set by a request against full/empty, cleared only by reset
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (i_wr_en && full_q) begin
                ovf_q <= 1'b1;
            end
            if (i_ack && empty_q) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign o_ovf = ovf_q;
    assign o_udf = udf_q;
`else
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_empty  = empty_q;
    assign o_full   = full_q;
    assign o_afull  = afull_q;
    assign o_aempty = aempty_q;
    assign o_count  = count_q;

endmodule

// File: tb/tb_zap_sync_fifo_flex.sv
// Directed bench for zap_sync_fifo_flex: one FWFT instance and one
// registered-read instance, both DEPTH=4, WIDTH=8.
module tb_zap_sync_fifo_flex;

`ifdef ZAP_SYNC_FIFO_ERR_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       rstN;

    logic       fFlush, fWr, fAck;
    logic [7:0] fData, fDataO;
    logic       fValid, fEmpty, fFull, fAfull, fAempty, fOvf, fUdf;
    logic [2:0] fCount;

    logic       rFlush, rWr, rAck;
    logic [7:0] rData, rDataO;
    logic       rValid, rEmpty, rFull, rAfull, rAempty, rOvf, rUdf;
    logic [2:0] rCount;

    int checks = 0;
    int fails  = 0;

    zap_sync_fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(1)) dutF (
        .i_clk(clk), .i_reset_n(rstN), .i_flush(fFlush), .i_wr_en(fWr),
        .i_data(fData), .i_ack(fAck), .o_data(fDataO), .o_valid(fValid),
        .o_empty(fEmpty), .o_full(fFull), .o_afull(fAfull), .o_aempty(fAempty),
        .o_count(fCount), .o_ovf(fOvf), .o_udf(fUdf)
    );

    zap_sync_fifo_flex #(.WIDTH(8), .DEPTH(4), .FWFT(0)) dutR (
        .i_clk(clk), .i_reset_n(rstN), .i_flush(rFlush), .i_wr_en(rWr),
        .i_data(rData), .i_ack(rAck), .o_data(rDataO), .o_valid(rValid),
        .o_empty(rEmpty), .o_full(rFull), .o_afull(rAfull), .o_aempty(rAempty),
        .o_count(rCount), .o_ovf(rOvf), .o_udf(rUdf)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        fFlush = 0; fWr = 0; fAck = 0; fData = 8'h00;
        rFlush = 0; rWr = 0; rAck = 0; rData = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (fCount !== 3'd0) begin fails++; $display("[TB] FAIL reset_fcount got %0d want 0", fCount); end
        checks++; if (fEmpty !== 1'b1) begin fails++; $display("[TB] FAIL reset_fempty got %b want 1", fEmpty); end
        checks++; if (fFull !== 1'b0) begin fails++; $display("[TB] FAIL reset_ffull got %b want 0", fFull); end
        checks++; if (fAfull !== 1'b0) begin fails++; $display("[TB] FAIL reset_fafull got %b want 0", fAfull); end
        checks++; if (fAempty !== 1'b1) begin fails++; $display("[TB] FAIL reset_faempty got %b want 1", fAempty); end
        checks++; if (fValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_fvalid got %b want 0", fValid); end
        checks++; if (fDataO !== 8'h00) begin fails++; $display("[TB] FAIL reset_fdata got %h want 00", fDataO); end
        checks++; if (fOvf !== 1'b0 || fUdf !== 1'b0) begin fails++; $display("[TB] FAIL reset_ferr got %b%b want 00", fOvf, fUdf); end
        checks++; if (rCount !== 3'd0) begin fails++; $display("[TB] FAIL reset_rcount got %0d want 0", rCount); end
        checks++; if (rEmpty !== 1'b1) begin fails++; $display("[TB] FAIL reset_rempty got %b want 1", rEmpty); end
        checks++; if (rValid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rvalid got %b want 0", rValid); end
        checks++; if (rDataO !== 8'h00) begin fails++; $display("[TB] FAIL reset_rdata got %h want 00", rDataO); end
        rstN = 1'b1;
    endtask

    task automatic test_fwft_fill();
        fWr = 1; fData = 8'hA1; stepClk();
        checks++; if (fCount !== 3'd1) begin fails++; $display("[TB] FAIL fill1_count got %0d want 1", fCount); end
        checks++; if (fEmpty !== 1'b0) begin fails++; $display("[TB] FAIL fill1_empty got %b want 0", fEmpty); end
        checks++; if (fDataO !== 8'hA1) begin fails++; $display("[TB] FAIL fill1_data got %h want a1", fDataO); end
        checks++; if (fValid !== 1'b1) begin fails++; $display("[TB] FAIL fill1_valid got %b want 1", fValid); end
        checks++; if (fAfull !== 1'b0) begin fails++; $display("[TB] FAIL fill1_afull got %b want 0", fAfull); end
        checks++; if (fAempty !== 1'b1) begin fails++; $display("[TB] FAIL fill1_aempty got %b want 1", fAempty); end
        fData = 8'hA2; stepClk();
        checks++; if (fCount !== 3'd2) begin fails++; $display("[TB] FAIL fill2_count got %0d want 2", fCount); end
        checks++; if (fAfull !== 1'b1) begin fails++; $display("[TB] FAIL fill2_afull got %b want 1", fAfull); end
        checks++; if (fAempty !== 1'b0) begin fails++; $display("[TB] FAIL fill2_aempty got %b want 0", fAempty); end
        checks++; if (fDataO !== 8'hA1) begin fails++; $display("[TB] FAIL fill2_data got %h want a1", fDataO); end
        fData = 8'hA3; stepClk();
        checks++; if (fFull !== 1'b0) begin fails++; $display("[TB] FAIL fill3_full got %b want 0", fFull); end
        fData = 8'hA4; stepClk();
        fWr = 0;
        checks++; if (fCount !== 3'd4) begin fails++; $display("[TB] FAIL fill4_count got %0d want 4", fCount); end
        checks++; if (fFull !== 1'b1) begin fails++; $display("[TB] FAIL fill4_full got %b want 1", fFull); end
        checks++; if (fDataO !== 8'hA1) begin fails++; $display("[TB] FAIL fill4_data got %h want a1", fDataO); end
    endtask

    task automatic test_full_wr_rd();
        fWr = 1; fData = 8'h55; fAck = 1; stepClk();
        fWr = 0;
        checks++; if (fCount !== 3'd3) begin fails++; $display("[TB] FAIL fullrw_count got %0d want 3", fCount); end
        checks++; if (fFull !== 1'b0) begin fails++; $display("[TB] FAIL fullrw_full got %b want 0", fFull); end
        checks++; if (fDataO !== 8'hA2) begin fails++; $display("[TB] FAIL fullrw_head got %h want a2", fDataO); end
        checks++; if (fOvf !== ERR_EN) begin fails++; $display("[TB] FAIL fullrw_ovf got %b want %b", fOvf, ERR_EN); end
        stepClk();
        checks++; if (fDataO !== 8'hA3) begin fails++; $display("[TB] FAIL drain_a3 got %h want a3", fDataO); end
        stepClk();
        checks++; if (fDataO !== 8'hA4 || fCount !== 3'd1) begin fails++; $display("[TB] FAIL drain_a4 got %h/%0d want a4/1", fDataO, fCount); end
        stepClk();
        fAck = 0;
        checks++; if (fEmpty !== 1'b1 || fCount !== 3'd0) begin fails++; $display("[TB] FAIL drain_empty got %b/%0d want 1/0", fEmpty, fCount); end
        checks++; if (fValid !== 1'b0) begin fails++; $display("[TB] FAIL drain_valid got %b want 0", fValid); end
    endtask

    task automatic test_registered_read();
        rWr = 1; rData = 8'h11; stepClk();
        checks++; if (rEmpty !== 1'b0 || rValid !== 1'b0) begin fails++; $display("[TB] FAIL reg_wr1 got empty %b valid %b want 0 0", rEmpty, rValid); end
        rData = 8'h22; stepClk();
        rWr = 0; rAck = 1;
        checks++; if (rCount !== 3'd2) begin fails++; $display("[TB] FAIL reg_count2 got %0d want 2", rCount); end
        stepClk();
        checks++; if (rValid !== 1'b1 || rDataO !== 8'h11) begin fails++; $display("[TB] FAIL reg_pop1 got %b/%h want 1/11", rValid, rDataO); end
        checks++; if (rCount !== 3'd1) begin fails++; $display("[TB] FAIL reg_pop1_count got %0d want 1", rCount); end
        stepClk();
        rAck = 0;
        checks++; if (rValid !== 1'b1 || rDataO !== 8'h22) begin fails++; $display("[TB] FAIL reg_pop2 got %b/%h want 1/22", rValid, rDataO); end
        checks++; if (rEmpty !== 1'b1 || rAempty !== 1'b1) begin fails++; $display("[TB] FAIL reg_pop2_flags got %b%b want 11", rEmpty, rAempty); end
        stepClk();
        checks++; if (rValid !== 1'b0 || rDataO !== 8'h22) begin fails++; $display("[TB] FAIL reg_hold got %b/%h want 0/22", rValid, rDataO); end
    endtask

    task automatic test_wrap();
        logic [7:0] expHead;
        fWr = 1; fData = 8'h00; stepClk();
        fData = 8'h01; stepClk();
        checks++; if (fCount !== 3'd2 || fDataO !== 8'h00) begin fails++; $display("[TB] FAIL wrap_prime got %0d/%h want 2/00", fCount, fDataO); end
        fAck = 1;
        for (int i = 2; i < 10; i++) begin
            fData = 8'(i);
            stepClk();
            expHead = 8'(i - 1);
            checks++; if (fDataO !== expHead || fCount !== 3'd2 || fFull !== 1'b0) begin fails++; $display("[TB] FAIL wrap_step%0d got %h/%0d/%b want %h/2/0", i, fDataO, fCount, fFull, expHead); end
        end
        fWr = 0; stepClk();
        checks++; if (fDataO !== 8'h09 || fCount !== 3'd1) begin fails++; $display("[TB] FAIL wrap_last got %h/%0d want 09/1", fDataO, fCount); end
        fWr = 1; fData = 8'h3C; stepClk();
        checks++; if (fDataO !== 8'h3C || fCount !== 3'd1 || fValid !== 1'b1) begin fails++; $display("[TB] FAIL bypass got %h/%0d/%b want 3c/1/1", fDataO, fCount, fValid); end
        fWr = 0; stepClk();
        fAck = 0;
        checks++; if (fEmpty !== 1'b1) begin fails++; $display("[TB] FAIL wrap_empty got %b want 1", fEmpty); end
    endtask

    task automatic test_flush();
        fWr = 1; fData = 8'h31; stepClk();
        fData = 8'h32; stepClk();
        fData = 8'h33; stepClk();
        checks++; if (fCount !== 3'd3 || fDataO !== 8'h31) begin fails++; $display("[TB] FAIL flush_pre got %0d/%h want 3/31", fCount, fDataO); end
        fFlush = 1; fData = 8'h99; fAck = 1; stepClk();
        fFlush = 0; fAck = 0; fData = 8'h77;
        checks++; if (fCount !== 3'd0 || fEmpty !== 1'b1 || fValid !== 1'b0) begin fails++; $display("[TB] FAIL flush_state got %0d/%b/%b want 0/1/0", fCount, fEmpty, fValid); end
        checks++; if (fAempty !== 1'b1 || fAfull !== 1'b0 || fFull !== 1'b0) begin fails++; $display("[TB] FAIL flush_flags got %b%b%b want 100", fAempty, fAfull, fFull); end
        checks++; if (fDataO !== 8'h31) begin fails++; $display("[TB] FAIL flush_datakeep got %h want 31", fDataO); end
        stepClk();
        fWr = 0;
        checks++; if (fDataO !== 8'h77 || fValid !== 1'b1 || fCount !== 3'd1) begin fails++; $display("[TB] FAIL flush_after got %h/%b/%0d want 77/1/1", fDataO, fValid, fCount); end
        fAck = 1; stepClk();
        fAck = 0;
        checks++; if (fEmpty !== 1'b1) begin fails++; $display("[TB] FAIL flush_drain got %b want 1", fEmpty); end
    endtask

    task automatic test_errors_and_async_reset();
        rAck = 1; stepClk();
        rAck = 0;
        checks++; if (rUdf !== ERR_EN || rValid !== 1'b0) begin fails++; $display("[TB] FAIL udf_set got %b/%b want %b/0", rUdf, rValid, ERR_EN); end
        rFlush = 1; stepClk();
        rFlush = 0;
        checks++; if (rUdf !== ERR_EN || rCount !== 3'd0) begin fails++; $display("[TB] FAIL udf_flush got %b/%0d want %b/0", rUdf, rCount, ERR_EN); end
        fWr = 1; fData = 8'h5A; stepClk();
        fWr = 0;
        checks++; if (fCount !== 3'd1 || fDataO !== 8'h5A) begin fails++; $display("[TB] FAIL prereset got %0d/%h want 1/5a", fCount, fDataO); end
        #2 rstN = 1'b0;
        #1;
        checks++; if (fCount !== 3'd0 || fEmpty !== 1'b1 || fValid !== 1'b0 || fDataO !== 8'h00) begin fails++; $display("[TB] FAIL async_reset got %0d/%b/%b/%h want 0/1/0/00", fCount, fEmpty, fValid, fDataO); end
        checks++; if (rUdf !== 1'b0 || fOvf !== 1'b0) begin fails++; $display("[TB] FAIL async_reset_err got %b%b want 00", rUdf, fOvf); end
        #2 rstN = 1'b1;
        stepClk();
        checks++; if (fCount !== 3'd0 || rUdf !== 1'b0) begin fails++; $display("[TB] FAIL post_reset got %0d/%b want 0/0", fCount, rUdf); end
    endtask

    // Scenario sequence and summary
    initial begin
        $display("[TB] starting zap_sync_fifo_flex bench");
        test_reset();
        test_fwft_fill();
        test_full_wr_rd();
        test_registered_read();
        test_wrap();
        test_flush();
        test_errors_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
